// File: rtl/button_event_gen.sv
// Turns one debounced button level into single-cycle press / short / long / repeat / release
// events plus a held level; every output is registered.
module button_event_gen #(
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned LONG_CYCLES   = 1000,
    parameter int unsigned REPEAT_CYCLES = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_level,
    output logic press_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic release_pulse,
    output logic held
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             press_nxt, short_nxt, long_nxt, repeat_nxt, release_nxt, held_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            release_pulse <= 1'b0;
            held          <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            press_pulse   <= press_nxt;
            short_pulse   <= short_nxt;
            long_pulse    <= long_nxt;
            repeat_pulse  <= repeat_nxt;
            release_pulse <= release_nxt;
            held          <= held_nxt;
        end
    end

    // Release is tested before the thresholds so a drop on a threshold cycle suppresses the pulse.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (btn_level) state_nxt = PRESS;
            end
            PRESS: begin
                if (!btn_level) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == LONG_LAST) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HOLD: begin
                if (!btn_level) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == REPEAT_LAST) begin
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        press_nxt   = 1'b0;
        short_nxt   = 1'b0;
        long_nxt    = 1'b0;
        repeat_nxt  = 1'b0;
        release_nxt = 1'b0;
        held_nxt    = (state_nxt != IDLE);
        case (state)
            IDLE:  press_nxt = btn_level;
            PRESS: begin
                short_nxt   = !btn_level;
                release_nxt = !btn_level;
                long_nxt    = btn_level && (cnt == LONG_LAST);
            end
            HOLD: begin
                release_nxt = !btn_level;
                repeat_nxt  = btn_level && (cnt == REPEAT_LAST);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_button_event_gen.sv
// Directed and random bench for button_event_gen: a behavioural model pushes expected
// output vectors to queues as stimulus is driven; they are popped after each clock edge.
module tb_button_event_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn0 = 1'b0, btn1 = 1'b0;
    logic p0, s0, l0, r0, rl0, h0;
    logic p1, s1, l1, r1, rl1, h1;

    always #5 clk = ~clk;

    button_event_gen #(.CNT_W(16), .LONG_CYCLES(4), .REPEAT_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .btn_level(btn0),
        .press_pulse(p0), .short_pulse(s0), .long_pulse(l0),
        .repeat_pulse(r0), .release_pulse(rl0), .held(h0)
    );

    button_event_gen #(.CNT_W(16), .LONG_CYCLES(1), .REPEAT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .btn_level(btn1),
        .press_pulse(p1), .short_pulse(s1), .long_pulse(l1),
        .repeat_pulse(r1), .release_pulse(rl1), .held(h1)
    );

    int n_cmp = 0;
    int n_fail = 0;
    logic [5:0] q0[$], q1[$];
    // model state: pressed flag and number of held samples since the press edge
    bit m0_pr = 0, m1_pr = 0;
    int m0_d = 0, m1_d = 0;
    // pulse tallies per dut: press, short, long, repeat, release
    int c0[5], c1[5];

    function automatic logic [5:0] vec0();
        return {p0, s0, l0, r0, rl0, h0};
    endfunction
    function automatic logic [5:0] vec1();
        return {p1, s1, l1, r1, rl1, h1};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Event-based model: long when d reaches L, repeat every R samples after that,
    // short only if the release edge comes no later than the long threshold edge.
    task automatic model(input int L, input int R, input logic b,
                         inout bit pr, inout int d, output logic [5:0] v);
        logic ps, ss, ls, rs, rls;
        ps = 0; ss = 0; ls = 0; rs = 0; rls = 0;
        if (b) begin
            if (!pr) begin
                ps = 1; pr = 1; d = 0;
            end else begin
                d++;
                ls = (d == L);
                rs = (d > L) && (((d - L) % R) == 0);
            end
        end else if (pr) begin
            rls = 1;
            ss  = (d + 1 <= L);
            pr  = 0;
        end
        v = {ps, ss, ls, rs, rls, logic'(pr)};
    endtask

    task automatic clear_tallies();
        for (int i = 0; i < 5; i++) begin
            c0[i] = 0;
            c1[i] = 0;
        end
    endtask

    task automatic step(input logic b0, input logic b1);
        logic [5:0] e0, e1, a0, a1;
        btn0 = b0;
        btn1 = b1;
        model(4, 2, b0, m0_pr, m0_d, e0);
        model(1, 1, b1, m1_pr, m1_d, e1);
        q0.push_back(e0);
        q1.push_back(e1);
        @(posedge clk);
        #1;
        a0 = vec0();
        a1 = vec1();
        chk("dut0_vec", 32'(a0), 32'(q0.pop_front()));
        chk("dut1_vec", 32'(a1), 32'(q1.pop_front()));
        chk("dut0_excl", 32'((a0[5] & |a0[4:1]) | (a0[4] & ~a0[1]) | (a0[3] & a0[2])), 32'd0);
        chk("dut1_excl", 32'((a1[5] & |a1[4:1]) | (a1[4] & ~a1[1]) | (a1[3] & a1[2])), 32'd0);
        for (int i = 0; i < 5; i++) begin
            c0[i] += int'(a0[5-i]);
            c1[i] += int'(a1[5-i]);
        end
    endtask

    task automatic check_tally0(input string tag, input int p, input int s, input int l,
                                input int r, input int rl);
        chk({tag, "_press"},   32'(c0[0]), 32'(p));
        chk({tag, "_short"},   32'(c0[1]), 32'(s));
        chk({tag, "_long"},    32'(c0[2]), 32'(l));
        chk({tag, "_repeat"},  32'(c0[3]), 32'(r));
        chk({tag, "_release"}, 32'(c0[4]), 32'(rl));
    endtask

    initial begin
        logic rb0, rb1;
        // reset state
        #1;
        chk("rst_vec0", 32'(vec0()), 32'd0);
        chk("rst_vec1", 32'(vec1()), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 0);

        // 1: two-sample press -> short + release
        clear_tallies();
        step(1, 0); step(1, 0); step(0, 0);
        for (int i = 0; i < 3; i++) step(0, 0);
        check_tally0("t1", 1, 1, 0, 0, 1);

        // 2: ten samples high -> long, two repeats, release without short
        clear_tallies();
        for (int i = 0; i < 10; i++) step(1, 0);
        step(0, 0);
        for (int i = 0; i < 3; i++) step(0, 0);
        check_tally0("t2", 1, 0, 1, 2, 1);

        // 3: release on the long-threshold edge -> short, never long
        clear_tallies();
        for (int i = 0; i < 4; i++) step(1, 0);
        step(0, 0);
        for (int i = 0; i < 3; i++) step(0, 0);
        check_tally0("t3", 1, 1, 0, 0, 1);

        // 4: LONG=1, REPEAT=1 instance
        clear_tallies();
        for (int i = 0; i < 4; i++) step(0, 1);
        step(0, 0);
        step(0, 0);
        chk("t4_press",   32'(c1[0]), 32'd1);
        chk("t4_short",   32'(c1[1]), 32'd0);
        chk("t4_long",    32'(c1[2]), 32'd1);
        chk("t4_repeat",  32'(c1[3]), 32'd2);
        chk("t4_release", 32'(c1[4]), 32'd1);

        // 5: reset while in HOLD with the button still down
        clear_tallies();
        for (int i = 0; i < 7; i++) step(1, 1);
        chk("t5_held_before", 32'(h0), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst_async0", 32'(vec0()), 32'd0);
        chk("t5_rst_async1", 32'(vec1()), 32'd0);
        @(posedge clk);
        #1;
        chk("t5_rst_edge0", 32'(vec0()), 32'd0);
        chk("t5_rst_edge1", 32'(vec1()), 32'd0);
        rst = 1'b0;
        m0_pr = 0; m1_pr = 0; m0_d = 0; m1_d = 0;
        clear_tallies();
        step(1, 1);
        chk("t5_repress", 32'(p0), 32'd1);
        step(0, 0);
        step(0, 0);
        chk("t5_release_cnt", 32'(c0[4]), 32'd1);

        // 6: random levels with sticky runs so long holds occur
        clear_tallies();
        rb0 = 0;
        rb1 = 0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 7) == 0) rb0 = ~rb0;
            if ($urandom_range(0, 2) == 0) rb1 = ~rb1;
            step(rb0, rb1);
        end
        chk("t6_balance0", 32'(c0[0]), 32'(c0[4] + int'(h0)));
        chk("t6_balance1", 32'(c1[0]), 32'(c1[4] + int'(h1)));
        chk("t6_short_le_rel0", 32'(c0[1] <= c0[4]), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
